// File: rtl/multiport_register_file_pkg.sv
// Shared types and default sizes for the integer register file.
package common;

    localparam int REGISTER_FILE_SIZE = 32;
    localparam int XLEN               = 32;
    localparam int ADDR_W             = $clog2(REGISTER_FILE_SIZE);

    typedef logic [ADDR_W-1:0] reg_id_t;

    typedef enum logic [1:0] {
        RF_RESET,
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker for the register file; only exists when REGFILE_SCOREBOARD_EN is defined.
`ifdef REGFILE_SCOREBOARD_EN
module regfile_scoreboard
    import common::*;
#(
    parameter int NUM_REGS = REGISTER_FILE_SIZE,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_run,
    input  logic                     i_issue_en,
    input  logic [ADDR_W-1:0]        i_issue_id,
    input  logic [NUM_WR-1:0]        i_wr_eff,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_id,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_id,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    function automatic logic id_valid(input logic [ADDR_W-1:0] id);
        return (id != '0) && (int'(id) < NUM_REGS);
    endfunction

    function automatic logic wr_hit(input logic [ADDR_W-1:0] id);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_eff[k] && (i_wr_id[k*ADDR_W +: ADDR_W] == id)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Clears are applied first so a same-cycle issue, being the newer producer, wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_run) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_wr_eff[k]) begin
                    w_busy_nxt[i_wr_id[k*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (i_issue_en && id_valid(i_issue_id)) begin
                w_busy_nxt[i_issue_id] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A write landing this cycle resolves the hazard without waiting for the edge.
    always_comb begin
        o_rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (i_run && id_valid(i_rd_id[i*ADDR_W +: ADDR_W])) begin
                o_rd_busy[i] = r_busy[i_rd_id[i*ADDR_W +: ADDR_W]]
                               && !wr_hit(i_rd_id[i*ADDR_W +: ADDR_W]);
            end
        end
    end

endmodule
`endif

// File: rtl/multiport_register_file.sv
// Multi-port integer register file with x0 hardwired to zero, write-to-read bypass and a post-reset clear engine.
// Defining REGFILE_SCOREBOARD_EN adds the pending-write scoreboard and its issue/read_busy ports.
module multiport_register_file
    import common::*;
#(
    parameter int XLEN     = common::XLEN,
    parameter int NUM_REGS = REGISTER_FILE_SIZE,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] read_id,
    output logic [NUM_RD*XLEN-1:0]   read_data,
    input  logic [NUM_WR-1:0]        write_en,
    input  logic [NUM_WR*ADDR_W-1:0] write_id,
    input  logic [NUM_WR*XLEN-1:0]   write_data,
    output logic                     ready
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_id,
    output logic [NUM_RD-1:0]        read_busy
`endif
);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic [XLEN-1:0]   r_regs [NUM_REGS];

    logic              w_run;
    logic [NUM_WR-1:0] w_wr_eff;

    function automatic logic id_valid(input logic [ADDR_W-1:0] id);
        return (id != '0) && (int'(id) < NUM_REGS);
    endfunction

    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] rid);
        logic [XLEN-1:0] val;
        val = '0;
        if (w_run && id_valid(rid)) begin
            val = r_regs[rid];
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wr_eff[k] && (write_id[k*ADDR_W +: ADDR_W] == rid)) begin
                    val = write_data[k*XLEN +: XLEN];
                end
            end
        end
        return val;
    endfunction

    assign w_run = (r_state == RF_RUN);
    assign ready = r_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                RF_RESET: begin
                    r_state <= RF_CLEAR;
                    r_cnt   <= '0;
                end
                RF_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
                        r_state <= RF_RUN;
                        r_ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    r_state <= RF_RUN;
                end
                default: begin
                    r_state <= RF_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            w_wr_eff[k] = w_run && write_en[k] && id_valid(write_id[k*ADDR_W +: ADDR_W]);
        end
    end

    // Ascending port order makes the highest-index writer the last assignment, so it wins.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (r_state == RF_CLEAR) begin
                r_regs[r_cnt] <= '0;
            end else if (w_run) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wr_eff[k]) begin
                        r_regs[write_id[k*ADDR_W +: ADDR_W]] <= write_data[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            read_data[i*XLEN +: XLEN] = read_port(read_id[i*ADDR_W +: ADDR_W]);
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .i_rst_n    (reset_n),
        .i_run      (w_run),
        .i_issue_en (issue_en),
        .i_issue_id (issue_id),
        .i_wr_eff   (w_wr_eff),
        .i_wr_id    (write_id),
        .i_rd_id    (read_id),
        .o_rd_busy  (read_busy)
    );
`endif

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomized scoreboard bench for multiport_register_file (3 read ports, 2 write ports).
module tb_multiport_register_file;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int RD = 3;
    localparam int WR = 2;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [RD*AW-1:0]   read_id;
    logic [RD*XL-1:0]   read_data;
    logic [WR-1:0]      write_en;
    logic [WR*AW-1:0]   write_id;
    logic [WR*XL-1:0]   write_data;
    logic               ready;
`ifdef REGFILE_SCOREBOARD_EN
    logic               issue_en;
    logic [AW-1:0]      issue_id;
    logic [RD-1:0]      read_busy;
`endif

    multiport_register_file #(
        .XLEN     (XL),
        .NUM_REGS (NR),
        .NUM_RD   (RD),
        .NUM_WR   (WR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_id    (read_id),
        .read_data  (read_data),
        .write_en   (write_en),
        .write_id   (write_id),
        .write_data (write_data),
        .ready      (ready)
`ifdef REGFILE_SCOREBOARD_EN
        ,
        .issue_en   (issue_en),
        .issue_id   (issue_id),
        .read_busy  (read_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RD*XL-1:0] rd;
        logic             rdy;
        logic [RD-1:0]    busy;
        string            tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: architectural contents, ready flag, cycles left in the clear, pending bits.
    logic [XL-1:0] m_mem [NR];
    bit            m_ready = 1'b0;
    int            m_left  = 0;
    bit [NR-1:0]   m_busy  = '0;

    task automatic chk(input string tag, input string what, input logic [XL-1:0] act, input logic [XL-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s %s: actual %h required %h", tag, what, act, req);
    endtask

    task automatic step(input string tag, input logic rn, input logic [1:0] we,
                        input logic [4:0] wid0, input logic [4:0] wid1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic ie, input logic [4:0] iid);
        exp_t          e;
        logic [4:0]    rr  [RD];
        logic [4:0]    wid [WR];
        logic [31:0]   wd  [WR];
        logic [31:0]   v;
        bit            hit;
        rr[0] = r0; rr[1] = r1; rr[2] = r2;
        wid[0] = wid0; wid[1] = wid1; wd[0] = wd0; wd[1] = wd1;
        #1;
        reset_n    = rn;
        write_en   = we;
        write_id   = {wid1, wid0};
        write_data = {wd1, wd0};
        read_id    = {r2, r1, r0};
`ifdef REGFILE_SCOREBOARD_EN
        issue_en   = ie;
        issue_id   = iid;
`endif
        e.tag  = tag;
        e.rdy  = m_ready;
        e.rd   = '0;
        e.busy = '0;
        for (int i = 0; i < RD; i++) begin
            if (m_ready && rr[i] != 0) begin
                v   = m_mem[rr[i]];
                hit = 1'b0;
                for (int k = 0; k < WR; k++) begin
                    if (we[k] && wid[k] == rr[i]) begin
                        v   = wd[k];
                        hit = 1'b1;
                    end
                end
                e.rd[i*XL +: XL] = v;
                e.busy[i]        = m_busy[rr[i]] && !hit;
            end
        end
        q.push_back(e);
        @(posedge clk);
        if (!rn) begin
            m_ready = 1'b0;
            m_left  = NR;
            m_busy  = '0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int j = 0; j < NR; j++) m_mem[j] = '0;
            end
        end else begin
            for (int k = 0; k < WR; k++) begin
                if (we[k] && wid[k] != 0) begin
                    m_mem[wid[k]]  = wd[k];
                    m_busy[wid[k]] = 1'b0;
                end
            end
            if (ie && iid != 0) m_busy[iid] = 1'b1;
        end
    endtask

    task automatic rd3(input string tag, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        step(tag, 1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, r0, r1, r2, 1'b0, 5'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, "ready", {31'd0, ready}, {31'd0, e.rdy});
            for (int i = 0; i < RD; i++) begin
                chk(e.tag, $sformatf("read_data[%0d]", i), read_data[i*XL +: XL], e.rd[i*XL +: XL]);
`ifdef REGFILE_SCOREBOARD_EN
                chk(e.tag, $sformatf("read_busy[%0d]", i), {31'd0, read_busy[i]}, {31'd0, e.busy[i]});
`endif
            end
        end
    end

    initial begin
        logic [4:0] ra, rb, rc, wa, wb, ii;
        reset_n    = 1'b0;
        write_en   = '0;
        write_id   = '0;
        write_data = '0;
        read_id    = '0;
`ifdef REGFILE_SCOREBOARD_EN
        issue_en   = 1'b0;
        issue_id   = '0;
`endif
        @(posedge clk);
        m_ready = 1'b0;
        m_left  = NR;
        m_busy  = '0;
        step("reset", 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0);

        for (int c = 0; c < NR; c++) begin
            if (c == 3) step("clear_wr", 1'b1, 2'b01, 5'd5, 5'd0, 32'hDEAD, 32'd0, 5'd5, 5'd5, 5'd0, 1'b1, 5'd9);
            else        rd3("clear", 5'd5, 5'd5, 5'd0);
        end
        rd3("x5_after_clear", 5'd5, 5'd5, 5'd0);

        step("x0_write", 1'b1, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        rd3("x0_next", 5'd0, 5'd0, 5'd0);

        step("x7_conflict", 1'b1, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd7, 5'd7, 1'b0, 5'd0);
        rd3("x7_next", 5'd7, 5'd7, 5'd7);

        step("x1x2_write", 1'b1, 2'b11, 5'd1, 5'd2, 32'd5, 32'd6, 5'd1, 5'd2, 5'd1, 1'b0, 5'd0);
        rd3("multi_read", 5'd1, 5'd2, 5'd1);

        step("issue_x9", 1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9, 5'd0, 1'b1, 5'd9);
        rd3("x9_busy", 5'd9, 5'd9, 5'd0);
        step("x9_writeback", 1'b1, 2'b01, 5'd9, 5'd0, 32'h99, 32'd0, 5'd9, 5'd9, 5'd0, 1'b0, 5'd0);
        rd3("x9_idle", 5'd9, 5'd9, 5'd0);
        step("x9_issue_wr", 1'b1, 2'b10, 5'd0, 5'd9, 32'd0, 32'h100, 5'd9, 5'd0, 5'd9, 1'b1, 5'd9);
        rd3("x9_still_busy", 5'd9, 5'd9, 5'd0);

        step("x3_write", 1'b1, 2'b01, 5'd3, 5'd0, 32'hAA, 32'd0, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0);
        rd3("x3_read", 5'd3, 5'd3, 5'd9);
        step("mid_reset", 1'b0, 2'b01, 5'd3, 5'd0, 32'h55, 32'd0, 5'd3, 5'd3, 5'd9, 1'b1, 5'd4);
        for (int c = 0; c < NR; c++) begin
            step("clear2", 1'b1, 2'b11, 5'd3, 5'd3, $urandom, $urandom, 5'd3, 5'd9, 5'd3, 1'b1, 5'd3);
        end
        rd3("x3_cleared", 5'd3, 5'd9, 5'd3);

        for (int n = 0; n < 500; n++) begin
            ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, NR - 1));
            rb = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, NR - 1));
            rc = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            wb = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            ii = 5'($urandom_range(0, 7));
            step("random", ($urandom_range(0, 99) != 0), 2'($urandom_range(0, 3)), wa, wb,
                 $urandom, $urandom, ra, rb, rc, 1'($urandom_range(0, 1)), ii);
        end
        rd3("final", 5'd1, 5'd2, 5'd3);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: actual %0d pending entries required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised integer register file for the pipelined core, with NUM_RD read ports and NUM_WR write ports, configurable width and depth.
- Register 0 is hardwired to zero; reads bypass same-cycle writes.
- After reset, a sequential init engine clears the array one entry per cycle; `ready` signals completion.
- Sits between decode (reads, issue) and writeback (writes). An optional scoreboard tracks pending writes for hazard detection.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, never overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- read_id  in  NUM_RD*ADDR_W  packed read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- write_en  in  NUM_WR  per-port write enable.
- write_id  in  NUM_WR*ADDR_W  packed write indices.
- write_data  in  NUM_WR*XLEN  packed write data.
- ready  out  1  high once the init clear has finished.
- issue_en  in  1  mark issue_id as pending; present only with the macro.
- issue_id  in  ADDR_W  destination register of the issuing instruction; present only with the macro.
- read_busy  out  NUM_RD  per-read-port pending flag; present only with the macro.

Behaviour:
- States: RESET, CLEAR, RUN.
- While reset_n=0 at a clock edge:
  - state <= CLEAR, clear counter <= 0, ready <= 0.
  - All busy bits <= 0.
  - The array is not touched in that cycle.
- CLEAR:
  - Each cycle: registers[cnt] <= 0, cnt <= cnt+1.
  - When cnt = NUM_REGS-1: state <= RUN, ready <= 1.
  - ready therefore rises on the NUM_REGS-th rising edge after reset_n is sampled high.
  - Writes and issues are ignored; all read_data read 0; read_busy = 0.
- Reset asserted mid-CLEAR or in RUN: clearing restarts from cnt=0 and ready drops on that edge.
- RUN writes:
  - write_en[k]=1 with write_id[k]!=0 updates the register on the rising edge.
  - Writes to id 0 are discarded.
  - Several ports writing the same id in one cycle: the highest-index port wins.
- RUN reads, purely combinational with zero latency:
  - read_id=0 returns 0.
  - Otherwise, if any enabled write port targets read_id (id!=0), return that port's write_data; highest-index match wins.
  - Otherwise return the stored value.
- Reset values: ready=0, read_data=0, read_busy=0.
- All index arithmetic is unsigned ADDR_W bits.
- If NUM_REGS is not a power of two, out-of-range ids read 0 and their writes are dropped.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined:
  - Adds a NUM_REGS-bit busy vector plus the ports issue_en, issue_id and read_busy.
  - In RUN, issue_en=1 with issue_id!=0 sets busy[issue_id] at the next edge.
  - Any effective write to id j clears busy[j] at the next edge.
  - Issue and write to the same id in one cycle: the set wins, because it is the newer producer.
  - busy[0] is always 0.
  - read_busy[i] = busy[read_id[i]] AND NOT (a same-cycle effective write to read_id[i]). This lets writeback resolve the hazard without a stall cycle.
- Undefined: the busy vector and the ports issue_en, issue_id and read_busy do not exist; the block is a pure register file with init.

Decomposition:
- Package common holds:
  - REGISTER_FILE_SIZE (the NUM_REGS default) and XLEN;
  - typedef reg_id_t (logic [ADDR_W-1:0]);
  - typedef rf_state_t enum {RF_RESET, RF_CLEAR, RF_RUN}.
- One sub-module, regfile_scoreboard, holds the busy vector, its set/clear priority and the read_busy lookup. It is instantiated only under REGFILE_SCOREBOARD_EN.

Test Plan:
- Init: reset_n low 2 cycles, then high.
  - ready=0 for 32 edges, ready=1 after the 32nd.
  - A write of 0xDEAD to x5 during CLEAR is ignored; read x5 = 0 afterwards.
- Zero register: write 0xFFFFFFFF to x0 in RUN -> read x0 = 0 on both ports, same and next cycle.
- Bypass and write conflict (NUM_WR=2):
  - port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle.
  - read x7 shows 0x22 that cycle and 0x22 after the edge.
- Reset mid-operation:
  - Write x3=0xAA in RUN, assert reset_n for 1 cycle.
  - ready drops; after 32 clear cycles read x3 = 0.
- Scoreboard (macro on):
  - issue x9 -> read_busy=1 next cycle.
  - A write to x9 gives read_busy=0 in the same cycle via bypass.
  - A simultaneous issue and write to x9 leaves busy set.
- Multi-read: NUM_RD=3 reading x1, x2, x1 after writing x1=5, x2=6 -> outputs 5, 6, 5.
